// File: rtl/junction_controller_if.sv
// Request and lamp signals between the junction controller and its environment.
// Pedestrian signals (ped_req, walk) exist only when PED_CROSSING_EN is defined.
interface junction_controller_if;
  logic req_ns;
  logic req_ew;
  logic ns_red;
  logic ns_amber;
  logic ns_green;
  logic ew_red;
  logic ew_amber;
  logic ew_green;
`ifdef PED_CROSSING_EN
  logic ped_req;
  logic walk;
`endif

  modport master (
    output req_ns, output req_ew,
    input  ns_red, input ns_amber, input ns_green,
    input  ew_red, input ew_amber, input ew_green
`ifdef PED_CROSSING_EN
    , output ped_req, input walk
`endif
  );

  modport slave (
    input  req_ns, input req_ew,
    output ns_red, output ns_amber, output ns_green,
    output ew_red, output ew_amber, output ew_green
`ifdef PED_CROSSING_EN
    , input ped_req, output walk
`endif
  );
endinterface

// File: rtl/junction_controller.sv
// Two-approach traffic junction sequencer with registered lamp drives.
// Optional pedestrian phase enabled by defining PED_CROSSING_EN.
//
// state      | meaning
// ST_ALL_RED | both approaches red, clearance interval
// ST_NS_RA   | north-south red+amber
// ST_NS_G    | north-south green
// ST_NS_A    | north-south amber
// ST_EW_RA   | east-west red+amber
// ST_EW_G    | east-west green
// ST_EW_A    | east-west amber
// ST_PED_WALK| both red, walk lamp lit (PED_CROSSING_EN only)
module junction_controller #(
  parameter int unsigned GREEN_MIN   = 10,
  parameter int unsigned AMBER_T     = 3,
  parameter int unsigned RED_AMBER_T = 2,
  parameter int unsigned ALL_RED_T   = 2
`ifdef PED_CROSSING_EN
  , parameter int unsigned PED_T     = 8
`endif
) (
  input logic                  clk,
  input logic                  rst_n,
  junction_controller_if.slave bus
);

  typedef enum logic [2:0] {
    ST_ALL_RED,
    ST_NS_RA,
    ST_NS_G,
    ST_NS_A,
    ST_EW_RA,
    ST_EW_G,
    ST_EW_A
`ifdef PED_CROSSING_EN
    , ST_PED_WALK
`endif
  } state_t;

  localparam logic [7:0] GREEN_LAST   = 8'(GREEN_MIN - 1);
  localparam logic [7:0] AMBER_LAST   = 8'(AMBER_T - 1);
  localparam logic [7:0] RA_LAST      = 8'(RED_AMBER_T - 1);
  localparam logic [7:0] ALL_RED_LAST = 8'(ALL_RED_T - 1);
`ifdef PED_CROSSING_EN
  localparam logic [7:0] PED_LAST     = 8'(PED_T - 1);
`endif

  state_t     state, next_state;
  logic [7:0] cnt;
  logic       last_ns;
  logic       pend_ns, pend_ew;
  logic       set_ns, set_ew, clr_ns, clr_ew;
  logic       ped_dem;
  logic [5:0] lamps_q, lamps_nxt;

`ifdef PED_CROSSING_EN
  logic pend_ped, set_ped, clr_ped, walk_q;
  assign ped_dem = pend_ped;
  assign set_ped = bus.ped_req && (state != ST_PED_WALK);
  assign clr_ped = (next_state == ST_PED_WALK) && (state != ST_PED_WALK);
  assign bus.walk = walk_q;
`else
  assign ped_dem = 1'b0;
`endif

  // Demand is ignored while that approach is already being served.
  assign set_ns = bus.req_ns && (state != ST_NS_RA) && (state != ST_NS_G);
  assign set_ew = bus.req_ew && (state != ST_EW_RA) && (state != ST_EW_G);
  assign clr_ns = (next_state == ST_NS_RA) && (state != ST_NS_RA);
  assign clr_ew = (next_state == ST_EW_RA) && (state != ST_EW_RA);

  always_comb begin
    next_state = state;
    case (state)
      ST_ALL_RED: if (cnt == ALL_RED_LAST) begin
        next_state = last_ns ? ST_EW_RA : ST_NS_RA;
`ifdef PED_CROSSING_EN
        if (pend_ped) next_state = ST_PED_WALK;
`endif
      end
      ST_NS_RA: if (cnt == RA_LAST) next_state = ST_NS_G;
      ST_NS_G:  if (cnt >= GREEN_LAST && (pend_ew || ped_dem)) next_state = ST_NS_A;
      ST_NS_A:  if (cnt == AMBER_LAST) next_state = ST_ALL_RED;
      ST_EW_RA: if (cnt == RA_LAST) next_state = ST_EW_G;
      ST_EW_G:  if (cnt >= GREEN_LAST && (pend_ns || ped_dem)) next_state = ST_EW_A;
      ST_EW_A:  if (cnt == AMBER_LAST) next_state = ST_ALL_RED;
`ifdef PED_CROSSING_EN
      ST_PED_WALK: if (cnt == PED_LAST) begin
        if (last_ns) next_state = pend_ew ? ST_EW_RA : ST_NS_RA;
        else         next_state = pend_ns ? ST_NS_RA : ST_EW_RA;
      end
`endif
      default: next_state = ST_ALL_RED;
    endcase
  end

  // Lamp pattern {ns_r, ns_a, ns_g, ew_r, ew_a, ew_g} for the state being entered.
  always_comb begin
    lamps_nxt = 6'b100_100;
    case (next_state)
      ST_NS_RA: lamps_nxt = 6'b110_100;
      ST_NS_G:  lamps_nxt = 6'b001_100;
      ST_NS_A:  lamps_nxt = 6'b010_100;
      ST_EW_RA: lamps_nxt = 6'b100_110;
      ST_EW_G:  lamps_nxt = 6'b100_001;
      ST_EW_A:  lamps_nxt = 6'b100_010;
      default:  lamps_nxt = 6'b100_100;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_ALL_RED;
      cnt     <= '0;
      last_ns <= 1'b0;
      pend_ns <= 1'b0;
      pend_ew <= 1'b0;
      lamps_q <= 6'b100_100;
`ifdef PED_CROSSING_EN
      pend_ped <= 1'b0;
      walk_q   <= 1'b0;
`endif
    end else begin
      state <= next_state;
      if (next_state != state) cnt <= '0;
      else if (cnt != 8'hFF)   cnt <= cnt + 8'd1;
      if (next_state == ST_NS_G && state != ST_NS_G) last_ns <= 1'b1;
      if (next_state == ST_EW_G && state != ST_EW_G) last_ns <= 1'b0;
      pend_ns <= set_ns || (pend_ns && !clr_ns);
      pend_ew <= set_ew || (pend_ew && !clr_ew);
      lamps_q <= lamps_nxt;
`ifdef PED_CROSSING_EN
      pend_ped <= set_ped || (pend_ped && !clr_ped);
      walk_q   <= (next_state == ST_PED_WALK);
`endif
    end
  end

  assign bus.ns_red   = lamps_q[5];
  assign bus.ns_amber = lamps_q[4];
  assign bus.ns_green = lamps_q[3];
  assign bus.ew_red   = lamps_q[2];
  assign bus.ew_amber = lamps_q[1];
  assign bus.ew_green = lamps_q[0];

endmodule

// File: doc/junction_controller.md
JUNCTION_CONTROLLER -- requirements
Module: junction_controller

Interface
REQ-001 Parameters: GREEN_MIN, 10, min green cycles; AMBER_T, 3, amber cycles; RED_AMBER_T, 2, red+amber cycles; ALL_RED_T, 2, all-red cycles; PED_T, 8, walk cycles. Each 1..255.
REQ-002 One clock; reset is synchronous and active-low.
REQ-003 clk  in  1  clock; all state changes on posedge.
REQ-004 rst_n  in  1  synchronous active-low reset.
REQ-005 req_ns  in  1  vehicle demand, north-south; sampled each edge.
REQ-006 req_ew  in  1  vehicle demand, east-west.
REQ-007 ped_req  in  1  pedestrian button; present only with PED_CROSSING_EN.
REQ-008 ns_red, ns_amber, ns_green  out  1 each  registered NS lamp drives.
REQ-009 ew_red, ew_amber, ew_green  out  1 each  registered EW lamp drives.
REQ-010 walk  out  1  registered pedestrian walk lamp; present only with PED_CROSSING_EN.

Function
REQ-011 States: ALL_RED, NS_RA, NS_G, NS_A, EW_RA, EW_G, EW_A, PED_WALK (macro only).
REQ-012 Lamps decoded from state, registered, change on the state-change edge: X_RA red+amber; X_G green; X_A amber; other approach red; ALL_RED/PED_WALK both red; walk=1 only in PED_WALK.
REQ-013 Never both approaches non-red in the same cycle; never green directly after red.
REQ-014 8-bit phase counter cleared on every state entry; timed state X held exactly its parameter cycles (RA: RED_AMBER_T, A: AMBER_T, ALL_RED: ALL_RED_T, PED_WALK: PED_T).
REQ-015 In X_G the counter saturates at 255; exit to X_A when count >= GREEN_MIN-1 and opposite pend (or pend_ped) set; otherwise green held indefinitely.
REQ-016 Sequences: X_RA -> X_G -> X_A -> ALL_RED; last_dir register set to X on X_G entry.
REQ-017 ALL_RED exit: pend_ped set -> PED_WALK; else RA of direction != last_dir.
REQ-018 PED_WALK exit: RA of direction != last_dir if its pend set, else RA of last_dir.
REQ-019 pend_ns/pend_ew set by req_x=1 except while X is in X_RA or X_G (ignored there); cleared on X_RA entry; set wins over clear in same cycle.
REQ-020 pend_ped set by ped_req=1 except in PED_WALK; cleared on PED_WALK entry; set wins over clear.
REQ-021 Simultaneous opposite and ped demand at green exit: pedestrian served after ALL_RED, then opposite approach.

Reset
REQ-022 rst_n=0 at posedge: state ALL_RED, counter 0, last_dir EW, all pend 0; ns_red=ew_red=1, all amber/green 0, walk 0.
REQ-023 Reset mid-phase (any state) takes effect on that edge; lamps show reset values next cycle.
REQ-024 After release, first exit from ALL_RED is NS_RA (pedestrian first if ped_req seen).

Configuration
REQ-025 Macro PED_CROSSING_EN: defined -> ped_req, walk, pend_ped, PED_WALK, PED_T present; undefined -> those absent, ALL_RED exits per REQ-017 without the pedestrian branch.

Verification
REQ-026 Reset release, no requests -> 2 cycles ALL_RED, 2 NS_RA, then ns_green=1 held 100+ cycles.
REQ-027 In NS_G, pulse req_ew 1 cycle at count 3 -> ns_green for 10 cycles total, ns_amber 3, all red 2, EW red+amber 2, ew_green.
REQ-028 req_ns and req_ew both held high -> alternation NS/EW with 10-cycle greens; check REQ-013 each cycle.
REQ-029 (PED_CROSSING_EN) ped_req pulse during NS_G, no vehicle demand -> after 10 green, 3 amber, 2 all-red, walk=1 8 cycles, then NS_RA.
REQ-030 ped_req and req_ew set during NS_G -> walk 8 cycles, then EW_RA; pend_ped and pend_ew cleared.
REQ-031 rst_n=0 one cycle during EW_A -> next cycle both red, walk 0; sequence restarts per REQ-026.
